// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// EtherNeco sync-timer node: shared state type, command bits and slot helper.
package jellyvl_etherneco_synctimer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_TIME,
        ST_SKIP,
        ST_OFFSET,
        ST_DONE
    } cmd_state_t;

    localparam int unsigned CMD_BIT_VALID    = 0;
    localparam int unsigned CMD_BIT_OVERRIDE = 1;

    // Byte position of this node's slot; only meaningful for node != 0.
    function automatic logic [15:0] slot_pos(
        input int unsigned hdr,
        input int unsigned tim,
        input int unsigned ofs,
        input logic [15:0] node
    );
        return 16'(hdr + tim + ofs * (32'(node) - 32'd1));
    endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_node_if.sv
// Upstream command byte stream of the EtherNeco sync-timer node.
interface jellyvl_etherneco_synctimer_node_if;
    logic        first;
    logic        last;
    logic        valid;
    logic [15:0] pos;
    logic [7:0]  data;

    modport master (output first, last, valid, pos, data);
    modport slave  (input  first, last, valid, pos, data);
endinterface

// File: rtl/jellyvl_etherneco_slot_inserter.sv
// Replaces this node's slot bytes in the response stream with the elapsed time.
module jellyvl_etherneco_slot_inserter #(
    parameter int OFFSET_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [15:0]               base,
    input  logic [8*OFFSET_BYTES-1:0] elapsed,
    input  logic                      res_rx_start,
    input  logic                      res_rx_error,
    input  logic                      s_res_valid,
    input  logic [15:0]               s_res_pos,
    output logic [7:0]                m_res_data,
    output logic                      m_res_valid
);
    logic        suppress_q, suppress_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] idx;
    logic        hit;

    always_comb begin
        suppress_d = suppress_q;
        if (res_rx_start) suppress_d = 1'b0;
        if (res_rx_error) suppress_d = 1'b1;
        idx     = s_res_pos - base;
        hit     = enable && s_res_valid && !suppress_d
                  && (s_res_pos >= base)
                  && (idx < 16'(OFFSET_BYTES));
        valid_d = hit;
        data_d  = hit ? 8'(elapsed >> {idx, 3'b000}) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            suppress_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'd0;
        end else begin
            suppress_q <= suppress_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign m_res_valid = valid_q;
    assign m_res_data  = data_q;
endmodule

// File: rtl/jellyvl_etherneco_synctimer_node.sv
// EtherNeco sync-timer node front end: command parse, correction, turnaround stamp.
// Optional length check enabled by JELLYVL_SYNCTIMER_LENGTH_CHECK_EN.
module jellyvl_etherneco_synctimer_node
    import jellyvl_etherneco_synctimer_pkg::*;
#(
    parameter int TIME_BYTES   = 8,
    parameter int OFFSET_BYTES = 4,
    parameter int HEADER_BYTES = 1,
    parameter int NODE_WIDTH   = 8
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic [8*TIME_BYTES-1:0] current_time,
    input  logic                    cmd_rx_start,
    input  logic                    cmd_rx_end,
    input  logic                    cmd_rx_error,
    input  logic [15:0]             cmd_rx_length,
    input  logic [NODE_WIDTH-1:0]   cmd_rx_node,
    jellyvl_etherneco_synctimer_node_if.slave s_cmd,
    input  logic                    res_rx_start,
    input  logic                    res_rx_error,
    input  logic [15:0]             s_res_pos,
    input  logic                    s_res_valid,
    output logic [7:0]              m_res_data,
    output logic                    m_res_valid,
    output logic [8*TIME_BYTES-1:0] correct_time,
    output logic                    correct_override,
    output logic                    correct_valid,
    output logic                    cmd_reject
);
    localparam int TW = 8 * TIME_BYTES;
    localparam int OW = 8 * OFFSET_BYTES;

    cmd_state_t  state_q, state_d, st;
    logic [7:0]  cmd_q, cmd_d;
    logic [TW-1:0] time_q, time_d;
    logic [OW-1:0] offset_q, offset_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [OW-1:0] start_q, start_d;
    logic [OW-1:0] elapsed_q, elapsed_d;
    logic        started_q, started_d;
    logic [TW-1:0] ctime_q, ctime_d;
    logic        cvalid_q, cvalid_d;
    logic        cover_q, cover_d;
    logic        reject_q, reject_d;
    logic [15:0] slot;
    logic        node_zero;
    logic        len_ok;
    logic        accept;
    logic        unused;

    assign slot = slot_pos(HEADER_BYTES, TIME_BYTES, OFFSET_BYTES,
                           16'(cmd_rx_node));
    assign node_zero = (cmd_rx_node == '0);

`ifdef JELLYVL_SYNCTIMER_LENGTH_CHECK_EN
    assign len_ok = 32'(cmd_rx_length) >= 32'(HEADER_BYTES + TIME_BYTES)
                    + 32'(OFFSET_BYTES) * 32'(cmd_rx_node);
    assign unused = ^{s_cmd.last, current_time};
`else
    assign len_ok = 1'b1;
    assign unused = ^{s_cmd.last, current_time, cmd_rx_length};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            time_q    <= '0;
            offset_q  <= '0;
            cnt_q     <= '0;
            start_q   <= '0;
            elapsed_q <= '0;
            started_q <= 1'b0;
            ctime_q   <= '0;
            cvalid_q  <= 1'b0;
            cover_q   <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            time_q    <= time_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            elapsed_q <= elapsed_d;
            started_q <= started_d;
            ctime_q   <= ctime_d;
            cvalid_q  <= cvalid_d;
            cover_q   <= cover_d;
            reject_q  <= reject_d;
        end
    end

    // Frame parser: a new frame restarts from CMD regardless of state.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        time_d   = time_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        st       = state_q;
        if (cmd_rx_start || s_cmd.first) begin
            st       = ST_CMD;
            state_d  = ST_CMD;
            time_d   = '0;
            offset_d = '0;
            cnt_d    = '0;
        end
        if (s_cmd.valid) begin
            case (st)
                ST_CMD: begin
                    if (s_cmd.pos == 16'd0) begin
                        cmd_d   = s_cmd.data;
                        cnt_d   = '0;
                        state_d = ST_TIME;
                    end
                end
                ST_TIME: begin
                    for (int i = 0; i < TIME_BYTES; i++)
                        if (cnt_q == 4'(i)) time_d[8*i +: 8] = s_cmd.data;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(TIME_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = node_zero ? ST_DONE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (s_cmd.pos == slot) begin
                        offset_d[7:0] = s_cmd.data;
                        cnt_d   = 4'd1;
                        state_d = (OFFSET_BYTES == 1) ? ST_DONE : ST_OFFSET;
                    end
                end
                ST_OFFSET: begin
                    for (int i = 0; i < OFFSET_BYTES; i++)
                        if (cnt_q == 4'(i)) offset_d[8*i +: 8] = s_cmd.data;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(OFFSET_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
        if (cmd_rx_error || cmd_rx_end) state_d = ST_IDLE;
    end

    always_comb begin
        accept   = cmd_rx_end && !cmd_rx_error
                   && (state_q == ST_DONE) && len_ok;
        cvalid_d = accept && cmd_q[CMD_BIT_VALID];
        cover_d  = accept && cmd_q[CMD_BIT_OVERRIDE];
        ctime_d  = accept ? time_q + TW'(offset_q) : ctime_q;
        reject_d = cmd_rx_error || (cmd_rx_end && !accept);
        start_d   = cmd_rx_start ? current_time[OW-1:0] : start_q;
        started_d = started_q || cmd_rx_start;
        elapsed_d = elapsed_q;
        if (res_rx_start)
            elapsed_d = started_q ? current_time[OW-1:0] - start_q : '0;
    end

    jellyvl_etherneco_slot_inserter #(
        .OFFSET_BYTES (OFFSET_BYTES)
    ) u_inserter (
        .clk          (clk),
        .reset        (reset),
        .enable       (!node_zero),
        .base         (slot),
        .elapsed      (elapsed_q),
        .res_rx_start (res_rx_start),
        .res_rx_error (res_rx_error),
        .s_res_valid  (s_res_valid),
        .s_res_pos    (s_res_pos),
        .m_res_data   (m_res_data),
        .m_res_valid  (m_res_valid)
    );

    assign correct_time     = ctime_q;
    assign correct_override = cover_q;
    assign correct_valid    = cvalid_q;
    assign cmd_reject       = reject_q;
endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_node.sv
// Randomised bench for the sync-timer node against a frame-level model.
module tb_jellyvl_etherneco_synctimer_node;
    localparam int TB = 8;
    localparam int OB = 4;
    localparam int HB = 1;
    localparam int NS = 4;
    localparam int FL = HB + TB + OB * NS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [63:0] current_time;
    logic        cmd_rx_start, cmd_rx_end, cmd_rx_error;
    logic [15:0] cmd_rx_length;
    logic [7:0]  cmd_rx_node;
    logic        res_rx_start, res_rx_error;
    logic [15:0] s_res_pos;
    logic        s_res_valid;
    logic [7:0]  m_res_data;
    logic        m_res_valid;
    logic [63:0] correct_time;
    logic        correct_override, correct_valid, cmd_reject;

    jellyvl_etherneco_synctimer_node_if cmd_if();

    jellyvl_etherneco_synctimer_node dut (
        .reset            (reset),
        .clk              (clk),
        .current_time     (current_time),
        .cmd_rx_start     (cmd_rx_start),
        .cmd_rx_end       (cmd_rx_end),
        .cmd_rx_error     (cmd_rx_error),
        .cmd_rx_length    (cmd_rx_length),
        .cmd_rx_node      (cmd_rx_node),
        .s_cmd            (cmd_if),
        .res_rx_start     (res_rx_start),
        .res_rx_error     (res_rx_error),
        .s_res_pos        (s_res_pos),
        .s_res_valid      (s_res_valid),
        .m_res_data       (m_res_data),
        .m_res_valid      (m_res_valid),
        .correct_time     (correct_time),
        .correct_override (correct_override),
        .correct_valid    (correct_valid),
        .cmd_reject       (cmd_reject)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    logic        e_cv = 0, e_co = 0, e_rej = 0, e_rv = 0;
    logic [7:0]  e_rd = 0;
    logic [63:0] e_ct = 0;
    logic        nx_cv = 0, nx_co = 0, nx_rej = 0, nx_rv = 0;
    logic [7:0]  nx_rd = 0;
    logic [63:0] nx_ct = 0;

    logic [31:0] start_m = 0, elapsed_m = 0;
    bit          started_m = 0, sup_m = 0;

    logic        got_v [0:31];
    logic [7:0]  got_d [0:31];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("correct_valid", 64'(correct_valid), 64'(e_cv));
            check("correct_override", 64'(correct_override), 64'(e_co));
            check("cmd_reject", 64'(cmd_reject), 64'(e_rej));
            check("correct_time", correct_time, e_ct);
            check("m_res_valid", 64'(m_res_valid), 64'(e_rv));
            if (e_rv) check("m_res_data", 64'(m_res_data), 64'(e_rd));
        end
    end

    task automatic step();
        @(posedge clk);
        e_cv = nx_cv; e_co = nx_co; e_rej = nx_rej;
        e_ct = nx_ct; e_rv = nx_rv; e_rd = nx_rd;
        nx_cv = 0; nx_co = 0; nx_rej = 0; nx_rv = 0; nx_rd = 0;
        #1;
        current_time = current_time + 64'($urandom_range(1, 3));
    endtask

    task automatic idle_inputs();
        cmd_rx_start = 0; cmd_rx_end = 0; cmd_rx_error = 0;
        cmd_if.first = 0; cmd_if.last = 0; cmd_if.valid = 0;
        cmd_if.pos = 0; cmd_if.data = 0;
        res_rx_start = 0; res_rx_error = 0;
        s_res_valid = 0; s_res_pos = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        nx_ct = 0; started_m = 0; start_m = 0; elapsed_m = 0; sup_m = 0;
        step();
        step();
        reset = 0;
    endtask

    // Whole frame: start strobe, nbytes of payload, then end (+error).
    task automatic cmd_frame(input int node, input logic [7:0] cmd,
                             input logic [63:0] tm, input logic [31:0] ofs,
                             input int nbytes, input int len, input bit err);
        logic [7:0] b [0:FL-1];
        int need;
        bit acc, len_ok;
        for (int i = 0; i < FL; i++) b[i] = 8'($urandom);
        b[0] = cmd;
        for (int i = 0; i < TB; i++) b[HB+i] = tm[8*i +: 8];
        if (node > 0)
            for (int i = 0; i < OB; i++) b[HB+TB+OB*(node-1)+i] = ofs[8*i +: 8];
        cmd_rx_node = 8'(node);
        cmd_rx_length = 16'(len);
        cmd_rx_start = 1;
        start_m = current_time[31:0];
        started_m = 1;
        step();
        cmd_rx_start = 0;
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cmd_if.valid = 0; cmd_if.first = 0; cmd_if.last = 0;
                step();
            end
            cmd_if.valid = 1;
            cmd_if.pos = 16'(i);
            cmd_if.data = b[i];
            cmd_if.first = (i == 0);
            cmd_if.last = (i == nbytes - 1);
            step();
        end
        cmd_if.valid = 0; cmd_if.first = 0; cmd_if.last = 0;
        need = (node == 0) ? HB + TB : HB + TB + OB * node;
`ifdef JELLYVL_SYNCTIMER_LENGTH_CHECK_EN
        len_ok = (len >= HB + TB + OB * node);
`else
        len_ok = 1;
`endif
        acc = (nbytes >= need) && !err && len_ok;
        cmd_rx_end = 1;
        cmd_rx_error = err;
        nx_cv = acc && cmd[0];
        nx_co = acc && cmd[1];
        nx_rej = !acc;
        if (acc) nx_ct = tm + ((node == 0) ? 64'd0 : 64'(ofs));
        step();
        cmd_rx_end = 0;
        cmd_rx_error = 0;
    endtask

    task automatic res_frame(input int node, input int nbeats, input int err_at);
        int r;
        r = HB + TB + OB * (node - 1);
        cmd_rx_node = 8'(node);
        res_rx_start = 1;
        elapsed_m = started_m ? current_time[31:0] - start_m : 32'd0;
        sup_m = 0;
        step();
        res_rx_start = 0;
        for (int p = 0; p < nbeats; p++) begin
            s_res_valid = 1;
            s_res_pos = 16'(p);
            res_rx_error = (p == err_at);
            if (p == err_at) sup_m = 1;
            nx_rv = (node != 0) && !sup_m && (p >= r) && (p < r + OB);
            nx_rd = nx_rv ? 8'(elapsed_m >> (8 * (p - r))) : 8'd0;
            step();
            got_v[p] = m_res_valid;
            got_d[p] = m_res_data;
            res_rx_error = 0;
        end
        s_res_valid = 0;
    endtask

    initial begin
        int sumv;
        idle_inputs();
        reset = 1;
        current_time = 0;
        cmd_rx_node = 0;
        cmd_rx_length = 0;
        chk_en = 1;
        do_reset();
        check("reset correct_time", correct_time, 64'd0);
        check("reset correct_valid", 64'(correct_valid), 64'd0);

        current_time = 64'd100;
        cmd_frame(2, 8'h01, 64'h1000, 32'h20, 17, 17, 0);
        check("lit1 valid", 64'(correct_valid), 64'd1);
        check("lit1 override", 64'(correct_override), 64'd0);
        check("lit1 time", correct_time, 64'h1020);

        current_time = 64'd350;
        res_frame(2, 20, -1);
        check("lit res v12", 64'(got_v[12]), 64'd0);
        check("lit res v13", 64'(got_v[13]), 64'd1);
        check("lit res d13", 64'(got_d[13]), 64'hFA);
        check("lit res d14", 64'(got_d[14]), 64'h00);
        check("lit res d16", 64'(got_d[16]), 64'h00);
        check("lit res v17", 64'(got_v[17]), 64'd0);

        cmd_frame(2, 8'h03, 64'hFFFF_FFFF_FFFF_FFF0, 32'h20, 17, 17, 0);
        check("lit wrap time", correct_time, 64'h10);
        check("lit wrap override", 64'(correct_override), 64'd1);

        cmd_frame(1, 8'h01, 64'h1234, 32'h7, 13, 13, 1);
        check("lit err reject", 64'(cmd_reject), 64'd1);
        check("lit err valid", 64'(correct_valid), 64'd0);

        cmd_frame(3, 8'h01, 64'h777, 32'h5, 17, 17, 0);
        check("lit node3 reject", 64'(cmd_reject), 64'd1);

        cmd_frame(0, 8'h01, 64'h500, 32'h99, 9, 9, 0);
        check("lit node0 time", correct_time, 64'h500);
        res_frame(0, 20, -1);
        sumv = 0;
        for (int p = 0; p < 20; p++) sumv += int'(got_v[p]);
        check("lit node0 no insert", 64'(sumv), 64'd0);

        res_frame(2, 20, 14);
        check("lit suppress v15", 64'(got_v[15]), 64'd0);

        cmd_rx_node = 1;
        cmd_rx_start = 1;
        step();
        cmd_rx_start = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_if.valid = 1; cmd_if.pos = 16'(i);
            cmd_if.data = 8'(i + 1); cmd_if.first = (i == 0);
            step();
        end
        cmd_if.valid = 0; cmd_if.first = 0;
        do_reset();
        check("lit midreset time", correct_time, 64'd0);
        cmd_rx_end = 1;
        nx_rej = 1;
        step();
        cmd_rx_end = 0;
        check("lit idle end reject", 64'(cmd_reject), 64'd1);
        res_frame(1, 14, -1);
        check("lit no-start v9", 64'(got_v[9]), 64'd1);
        check("lit no-start d9", 64'(got_d[9]), 64'd0);

        for (int it = 0; it < 80; it++) begin
            int node, nb, len, need, ea;
            bit err;
            node = int'($urandom_range(0, NS));
            need = (node == 0) ? HB + TB : HB + TB + OB * node;
            if ($urandom_range(0, 3) == 0) nb = int'($urandom_range(0, FL));
            else nb = int'($urandom_range(need, FL));
            len = int'($urandom_range(HB + TB, FL));
            err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) current_time[31:0] = 32'hFFFF_FFF0;
            cmd_frame(node, 8'($urandom), {$urandom, $urandom}, $urandom,
                      nb, len, err);
            if ($urandom_range(0, 1) == 1) begin
                current_time = current_time + 64'($urandom_range(0, 1000));
                ea = -1;
                if ($urandom_range(0, 5) == 0) ea = int'($urandom_range(0, 29));
                res_frame(node, int'($urandom_range(HB + TB, 30)), ea);
            end
        end

        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jellyvl_etherneco_synctimer_node.md
# jellyvl_etherneco_synctimer_node

Parametrised synchronisation-timer front end for one EtherNeco ring node. It parses the timer command frame arriving on the upstream port: command byte, master time, and this node's entry in a per-node offset table. It then emits a time-correction request to the timer core, and stamps the measured cmd-to-response turnaround time into this node's slot of the returning response frame. It sits between the EtherNeco packet receivers and `jellyvl_synctimer_core`; the core is instantiated by the parent, not by this block.

## Interface
- `TIME_BYTES`, 8, bytes of master time in frame; timer width is 8*TIME_BYTES
- `OFFSET_BYTES`, 4, bytes per node offset/elapsed slot (1..8)
- `HEADER_BYTES`, 1, command bytes before the time field
- `NODE_WIDTH`, 8, width of node id
- `reset`  in  1  synchronous, active-high
- `clk`  in  1  single clock
- `current_time`  in  8*TIME_BYTES  free-running local time from the core
- `cmd_rx_start`, `cmd_rx_end`, `cmd_rx_error`  in  1  upstream frame strobes
- `cmd_rx_length`  in  16  upstream payload length, bytes
- `cmd_rx_node`  in  NODE_WIDTH  this node's id; 0 means no slot
- `s_cmd_first`, `s_cmd_last`, `s_cmd_valid`  in  1  upstream byte stream qualifiers
- `s_cmd_pos`  in  16  upstream byte position
- `s_cmd_data`  in  8  upstream byte
- `res_rx_start`, `res_rx_error`  in  1  response frame strobes
- `s_res_pos`  in  16  response byte position
- `s_res_valid`  in  1  response byte valid
- `m_res_data`  out  8  replacement byte
- `m_res_valid`  out  1  replacement strobe
- `correct_time`  out  8*TIME_BYTES  corrected time
- `correct_override`  out  1  hard set (1) or phase adjust (0)
- `correct_valid`  out  1  correction pulse
- `cmd_reject`  out  1  frame discarded pulse

## Operation
- Command FSM states: IDLE, CMD, TIME, SKIP, OFFSET, DONE.
- `cmd_rx_start` or `s_cmd_first`: go to CMD, from any state. Clear the time and offset registers to 0.
- Byte at position 0 with `s_cmd_valid`: latch the command byte; go to TIME.
- TIME: capture TIME_BYTES bytes, little-endian, into the time register. Go to SKIP at offset position P = HEADER_BYTES + TIME_BYTES + OFFSET_BYTES*(node-1).
- SKIP: wait until `s_cmd_pos == P`. Then go to OFFSET.
- OFFSET: capture OFFSET_BYTES bytes, little-endian. Then go to DONE.
- Node 0 skips the offset capture (offset = 0); go directly from TIME to DONE.
- On `cmd_rx_end`:
  - Accept if state is DONE and no error. Set `correct_override` = cmd[1], `correct_valid` = cmd[0], and `correct_time` = time + zero-extended offset, mod 2^(8*TIME_BYTES).
  - Otherwise pulse `cmd_reject`, with `correct_valid` = 0.
  - In both cases return to IDLE.
- `cmd_rx_error`: go to IDLE and pulse `cmd_reject`. Error on the same cycle as `cmd_rx_end` counts as an error.
- Turnaround measurement:
  - `cmd_rx_start` latches the low 8*OFFSET_BYTES bits of `current_time` as start.
  - `res_rx_start` latches elapsed = current_time_low − start, mod 2^(8*OFFSET_BYTES).
  - Elapsed is 0 until the first `cmd_rx_start` after reset.
- Response insertion:
  - R = HEADER_BYTES + TIME_BYTES + OFFSET_BYTES*(node-1).
  - For `s_res_valid` with R ≤ pos < R+OFFSET_BYTES, output elapsed byte (pos−R).
  - Node 0: never insert.
  - `res_rx_error` suppresses insertion until the next `res_rx_start`.

## Timing
- Reset values: all outputs 0; FSM IDLE; elapsed and start 0.
- Correction latency: `correct_*` and `cmd_reject` are one-cycle pulses, registered on the cycle after `cmd_rx_end` / `cmd_rx_error`. `correct_time` holds its value until the next acceptance.
- Response latency: `m_res_*` is registered one cycle after the `s_res_valid` beat; the bench aligns against the delayed stream.
- Elapsed latch happens at the `res_rx_start` edge.
- Insertion uses the value latched at the most recent `res_rx_start`.
- `cmd_rx_start` and `res_rx_start` in the same cycle: elapsed uses the old start value.
- Reset mid-frame: FSM goes to IDLE; no correction pulse and no reject.

## Configuration
- `JELLYVL_SYNCTIMER_LENGTH_CHECK_EN` defined: acceptance additionally requires `cmd_rx_length` ≥ HEADER_BYTES + TIME_BYTES + OFFSET_BYTES*node. A shorter frame pulses `cmd_reject`.
- Macro undefined: length is ignored, and DONE alone is sufficient.

## Structure
- Package `jellyvl_etherneco_synctimer_pkg` holds:
  - the state enum;
  - the command bit indices (VALID = 0, OVERRIDE = 1);
  - the function computing the slot position from the node id.
- Sub-module `jellyvl_etherneco_slot_inserter` covers the response byte replacement: position window compare plus registered mux.

## Test plan
- Defaults, node 2, length 17: cmd 0x01, time 0x0000_0000_0000_1000, offset 0x20 at pos 13..16 → `correct_valid` = 1, `correct_override` = 0, `correct_time` = 0x1020.
- cmd 0x03, time 0xFFFF_FFFF_FFFF_FFF0, offset 0x20 → `correct_time` = 0x10 (wrap), `correct_override` = 1.
- `cmd_rx_start` at `current_time` 100, `res_rx_start` at 350, node 2 → response pos 13..16 replaced by 0xFA, 0, 0, 0; other positions have `m_res_valid` = 0.
- `cmd_rx_error` asserted together with `cmd_rx_end` → `cmd_reject` = 1, `correct_valid` = 0.
- Node 3, frame length 17 with macro defined → `cmd_reject`; without macro, the frame ends in SKIP → `cmd_reject`.
- Node 0, cmd 0x01, time 0x500 → `correct_time` = 0x500, no response insertion.
